// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative EX-stage multiply/divide unit that owns the HI/LO registers.
// Ports:
//   Clock, Reset         rising-edge clock, synchronous active-high reset
//   Start, Op            HI/LO-writing request (1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO)
//   OperandA, OperandB   rs / rt values
//   HiLoRead             EX-stage instruction is MFHI/MFLO
//   Busy, Stall, Done    iterating, pipeline freeze request, one-cycle commit pulse
//   Hi_Out, Lo_Out       current HI / LO
module ex_muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Start,
  input  logic [2:0]      Op,
  input  logic [XLEN-1:0] OperandA,
  input  logic [XLEN-1:0] OperandB,
  input  logic            HiLoRead,
  output logic            Busy,
  output logic            Stall,
  output logic            Done,
  output logic [XLEN-1:0] Hi_Out,
  output logic [XLEN-1:0] Lo_Out
);
  localparam int CW = $clog2(ITER);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0] op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, orig_q, orig_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN:0] rem_q, rem_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d, done_q, done_d;
  logic is_md, is_signed, div_op;
  logic [XLEN-1:0] abs_a, abs_b, quot_fix, rem_fix;
  logic [XLEN:0] sum, shl, diff;
  logic [2*XLEN-1:0] prod_fix;
  assign is_md     = (Op >= 3'd1) && (Op <= 3'd4);
  assign is_signed = (Op == 3'd1) || (Op == 3'd3);
  assign div_op    = (op_q == 3'd3) || (op_q == 3'd4);
  assign abs_a     = (is_signed && OperandA[XLEN-1]) ? -OperandA : OperandA;
  assign abs_b     = (is_signed && OperandB[XLEN-1]) ? -OperandB : OperandB;
  // Multiply: the multiplier sits in acc low half and is consumed LSB-first as the sum shifts in.
  assign sum       = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
  // Divide: a_q shifts the dividend out MSB-first while quotient bits shift in at the bottom.
  assign shl       = {rem_q[XLEN-1:0], a_q[XLEN-1]};
  assign diff      = shl - {1'b0, b_q};
  // Sign flags are only ever set for signed ops, so unsigned results pass through untouched.
  assign prod_fix  = qneg_q ? -acc_q : acc_q;
  assign quot_fix  = (b_q == '0) ? '1 : (qneg_q ? -a_q : a_q);
  assign rem_fix   = (b_q == '0) ? orig_q : (rneg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0]);
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    orig_d  = orig_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    if (state_q == IDLE && Start && is_md) begin
      op_d    = Op;
      a_d     = abs_a;
      b_d     = abs_b;
      orig_d  = OperandA;
      qneg_d  = is_signed && (OperandA[XLEN-1] ^ OperandB[XLEN-1]);
      rneg_d  = is_signed && OperandA[XLEN-1];
      count_d = '0;
      acc_d   = {{XLEN{1'b0}}, abs_b};
      rem_d   = '0;
      state_d = RUN;
    end else if (state_q == IDLE && Start) begin
      hi_d = (Op == 3'd5) ? OperandA : hi_q;
      lo_d = (Op == 3'd6) ? OperandA : lo_q;
    end else if (state_q == RUN) begin
      count_d = count_q + 1'b1;
      acc_d   = div_op ? acc_q : {sum, acc_q[XLEN-1:1]};
      rem_d   = (div_op && !diff[XLEN]) ? diff : (div_op ? shl : rem_q);
      a_d     = div_op ? {a_q[XLEN-2:0], ~diff[XLEN]} : a_q;
      state_d = (count_q == CW'(ITER - 1)) ? FIX : RUN;
    end else if (state_q == FIX) begin
      hi_d    = div_op ? rem_fix : prod_fix[2*XLEN-1:XLEN];
      lo_d    = div_op ? quot_fix : prod_fix[XLEN-1:0];
      done_d  = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      count_q <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      orig_q  <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      orig_q  <= orig_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end
  assign Busy   = (state_q != IDLE);
  assign Stall  = Busy && (HiLoRead || Start);
  assign Done   = done_q;
  assign Hi_Out = hi_q;
  assign Lo_Out = lo_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed self-checking bench for ex_muldiv_unit.
module tb_ex_muldiv_unit;
  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  Op = 3'd0;
  logic [31:0] OperandA = '0;
  logic [31:0] OperandB = '0;
  logic        HiLoRead = 1'b0;
  logic        Busy, Stall, Done;
  logic [31:0] Hi_Out, Lo_Out;
  int checks = 0;
  int errors = 0;
  int busy_n;
  ex_muldiv_unit #(.XLEN(32), .ITER(32)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB), .HiLoRead(HiLoRead),
    .Busy(Busy), .Stall(Stall), .Done(Done), .Hi_Out(Hi_Out), .Lo_Out(Lo_Out)
  );
  always #5 Clock = ~Clock;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Called at a negedge: issue one request through its accepting edge, then drop Start.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    Op = op;
    OperandA = a;
    OperandB = b;
    @(posedge Clock);
    @(negedge Clock);
    Start = 1'b0;
    Op = 3'd0;
  endtask
  // Count Busy cycles until Done is seen, bounded so a dead DUT still reaches the summary.
  task automatic wait_done(output int busy);
    busy = 0;
    for (int i = 0; i < 40 && !Done; i++) begin
      busy += int'(Busy);
      @(negedge Clock);
    end
  endtask
  task automatic md(input string tag, input logic [2:0] op, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
    int n;
    issue(op, a, b);
    wait_done(n);
    check({tag, "_done"}, 32'(Done), 32'd1);
    check({tag, "_busy_cycles"}, n, 32'd33);
    check({tag, "_hi"}, Hi_Out, hi);
    check({tag, "_lo"}, Lo_Out, lo);
    @(negedge Clock);
    check({tag, "_done_pulse"}, 32'(Done), 32'd0);
  endtask
  initial begin
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_stall", 32'(Stall), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_hi", Hi_Out, 32'd0);
    check("rst_lo", Lo_Out, 32'd0);
    md("mult_neg", 3'd1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    md("multu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    md("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    md("divu_zero", 3'd4, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
    md("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    md("div_pos", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    // MFLO-style read right behind a MULT: stalls every busy cycle, released on Done.
    issue(3'd1, 32'd6, 32'd7);
    HiLoRead = 1'b1;
    for (int i = 0; i < 40 && !Done; i++) begin
      check("hazard_stall", 32'(Stall), 32'd1);
      @(negedge Clock);
    end
    check("hazard_done", 32'(Done), 32'd1);
    check("hazard_release", 32'(Stall), 32'd0);
    check("hazard_lo", Lo_Out, 32'd42);
    check("hazard_hi", Hi_Out, 32'd0);
    HiLoRead = 1'b0;
    @(negedge Clock);
    // Back-to-back MULT: the held second request is accepted on the Done cycle.
    issue(3'd1, 32'd2, 32'd3);
    Start = 1'b1;
    Op = 3'd1;
    OperandA = 32'd4;
    OperandB = 32'd5;
    check("b2b_stall", 32'(Stall), 32'd1);
    wait_done(busy_n);
    check("b2b_first_done", 32'(Done), 32'd1);
    check("b2b_first_lo", Lo_Out, 32'd6);
    check("b2b_done_nostall", 32'(Stall), 32'd0);
    @(posedge Clock);
    @(negedge Clock);
    Start = 1'b0;
    Op = 3'd0;
    check("b2b_second_busy", 32'(Busy), 32'd1);
    wait_done(busy_n);
    check("b2b_second_cycles", busy_n, 32'd33);
    check("b2b_second_lo", Lo_Out, 32'd20);
    @(negedge Clock);
    // NOP opcodes with Start are ignored.
    issue(3'd0, 32'd9, 32'd9);
    check("nop0_busy", 32'(Busy), 32'd0);
    issue(3'd7, 32'd9, 32'd9);
    check("nop7_busy", 32'(Busy), 32'd0);
    check("nop_lo", Lo_Out, 32'd20);
    // MTHI then MTLO on consecutive edges.
    Start = 1'b1;
    Op = 3'd5;
    OperandA = 32'hDEADBEEF;
    @(posedge Clock);
    @(negedge Clock);
    check("mthi_hi", Hi_Out, 32'hDEADBEEF);
    check("mthi_lo_kept", Lo_Out, 32'd20);
    check("mthi_busy", 32'(Busy), 32'd0);
    check("mthi_done", 32'(Done), 32'd0);
    Op = 3'd6;
    OperandA = 32'd1;
    @(posedge Clock);
    @(negedge Clock);
    Start = 1'b0;
    Op = 3'd0;
    check("mtlo_lo", Lo_Out, 32'd1);
    check("mtlo_hi_kept", Hi_Out, 32'hDEADBEEF);
    check("mtlo_busy", 32'(Busy), 32'd0);
    check("mtlo_done", 32'(Done), 32'd0);
    // Reset sampled at E10 of a DIVU aborts it.
    issue(3'd4, 32'd100, 32'd7);
    repeat (9) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_hi", Hi_Out, 32'd0);
    check("abort_lo", Lo_Out, 32'd0);
    check("abort_done", 32'(Done), 32'd0);
    repeat (30) @(negedge Clock);
    check("abort_no_late_done", 32'(Done), 32'd0);
    check("abort_lo_late", Lo_Out, 32'd0);
    md("divu_after_abort", 3'd4, 32'd100, 32'd7, 32'd2, 32'd14);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage. Consumes the ALUOp-decoded mult/div/mthi/mtlo request and the RF_RD1/RF_RD2 operands registered by the ID/EX stage register.
- Owns the architectural HI/LO registers.
- Raises Stall, which the hazard logic uses to drop WriteEnable on the IF/ID and ID/EX registers while a dependent instruction must wait.

Parameters:
- XLEN, 32, operand width. HI and LO are XLEN each.
- ITER, 32, iterations per mult/div. Must equal XLEN.

Ports:
- Clock  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high.
- Start  in  1  EX-stage instruction is a HI/LO-writing op (valid request).
- Op  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP.
- OperandA  in  XLEN  rs value (multiplicand/dividend; MTHI/MTLO source).
- OperandB  in  XLEN  rt value (multiplier/divisor).
- HiLoRead  in  1  EX-stage instruction is MFHI/MFLO.
- Busy  out  1  unit is iterating.
- Stall  out  1  freeze request to the upstream pipeline registers.
- Done  out  1  one-cycle pulse when a mult/div result is committed to HI/LO.
- Hi_Out  out  XLEN  current HI.
- Lo_Out  out  XLEN  current LO.

Behaviour:
- Reset: synchronous, active-high, clock Clock. State=IDLE, HI=0, LO=0, Done=0, iteration count=0, internal accumulators=0. Busy=0 and Stall=0 in the cycle after reset.
- Reset during RUN or FIX aborts the operation; HI/LO are not updated with partial results.
- States: IDLE, RUN, FIX.
- Busy = (state != IDLE), combinational from state.
- Stall = Busy & (HiLoRead | Start), combinational. The pipeline holds the requesting instruction, so Start/Op/operands remain stable while stalled.
- IDLE, Start=1, Op in {1..4}, sampled at edge E0:
  - Latch the operation.
  - Latch |A| and |B| for signed ops, raw values for unsigned ops.
  - Latch result-sign flags: product/quotient sign = A[31]^B[31]; remainder sign = A[31].
  - count=0; go to RUN.
- RUN: one iteration per edge, edges E1..E32. count increments; at count=ITER-1 go to FIX.
  - Multiply: shift-add into a 64-bit accumulator, one multiplier bit per cycle.
  - Divide: restoring shift-subtract, one quotient bit per cycle, 33-bit partial remainder.
- FIX, edge E33:
  - Apply two's-complement negation per the sign flags (signed ops only).
  - Write HI/LO; Done=1 for exactly the cycle after E33; go to IDLE.
- Mult/div latency: Start edge to HI/LO update is 33 edges. Busy is high for 33 cycles.
- Multiply result: HI=product[63:32], LO=product[31:0].
- Divide result: LO=quotient, HI=remainder.
- Divide by zero: full latency. LO=0xFFFFFFFF, HI=OperandA as latched (the original signed/unsigned dividend, not the magnitude).
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the magnitude algorithm and needs no special case.
- MTHI/MTLO in IDLE with Start=1: HI (or LO) <= OperandA at that edge. Stays in IDLE; no Done; no Busy.
- Start with Op NOP/7: ignored.
- Start while Busy: not accepted; Stall=1 until the edge after FIX. The request is then accepted in the first IDLE cycle.
- HiLoRead while Busy: Stall=1.
- HiLoRead in IDLE: no stall. Hi_Out/Lo_Out reflect all HI/LO writes made at or before the preceding edge.
- The cycle in which Done=1 is IDLE: new Start is accepted and HiLoRead sees the new HI/LO.
- OperandA/OperandB changes during RUN have no effect.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=7 -> Busy 33 cycles, Done pulse once; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Follow with DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=0x12345678, B=0 -> after 33 edges LO=0xFFFFFFFF, HI=0x12345678. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Hazard check:
  - MULT 6*7 started, HiLoRead=1 from the next cycle -> Stall=1 every Busy cycle; Stall=0 in the Done cycle with Lo_Out=42.
  - Back-to-back MULT while Busy -> second accepted on the Done cycle.
- MTHI A=0xDEADBEEF, then MTLO A=0x1 on consecutive cycles -> HI=0xDEADBEEF, LO=1 one edge each; Busy and Done never assert.
- Reset asserted at edge E10 of a DIVU 100/7 -> next cycle Busy=0, HI=LO=0, no Done. A new DIVU 100/7 then yields LO=14, HI=2.
